// File: rtl/rob_axi_pkg.sv
// Shared types and width helpers for the AXI R-beat response path.
package rob_axi_pkg;

    localparam int ID_W   = 4;
    localparam int DATA_W = 64;
    localparam int RESP_W = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
        logic              last;
    } r_entry_t;

    // Pointer width able to index entries 0..depth-1 (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rob_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is read combinationally.
module rob_sync_fifo
    import rob_axi_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push & ~do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop & ~do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/r_resp_buffer_sf.sv
// Outgoing AXI R-beat buffer with burst tracking and optional store-and-forward.
module r_resp_buffer_sf
    import rob_axi_pkg::*;
#(
    parameter int  ID_WIDTH   = 4,
    parameter int  DATA_WIDTH = 64,
    parameter int  RESP_WIDTH = 2,
    parameter int  DEPTH      = 16,
    parameter int  STORE_FWD  = 0,
    parameter int  AF_THRESH  = DEPTH - 2,
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_in_valid,
    output logic                  r_in_ready,
    input  logic [ID_WIDTH-1:0]   r_in_id,
    input  logic [DATA_WIDTH-1:0] r_in_data,
    input  logic [RESP_WIDTH-1:0] r_in_resp,
    input  logic                  r_in_last,
    output logic                  r_out_valid,
    input  logic                  r_out_ready,
    output logic [ID_WIDTH-1:0]   r_out_id,
    output logic [DATA_WIDTH-1:0] r_out_data,
    output logic [RESP_WIDTH-1:0] r_out_resp,
    output logic                  r_out_last,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      bursts,
    output logic                  cut_through
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } beat_t;

    localparam logic SF = (STORE_FWD != 0);

    beat_t in_beat;
    beat_t head;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  last_push;
    logic  last_pop;
    logic  force_q;
    logic  force_set;
    logic  force_clr;

    assign in_beat = '{id: r_in_id, data: r_in_data, resp: r_in_resp, last: r_in_last};

    rob_sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_beat),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign r_in_ready  = ~full;
    assign push        = r_in_valid & r_in_ready;
    // In store-and-forward the head is hidden until some burst is complete,
    // unless an oversize burst has forced release.
    assign r_out_valid = ~empty & (~SF | (bursts != '0) | force_q);
    assign pop         = r_out_valid & r_out_ready;
    assign r_out_id    = head.id;
    assign r_out_data  = head.data;
    assign r_out_resp  = head.resp;
    assign r_out_last  = head.last;
    assign almost_full = (count >= CNT_W'(AF_THRESH));

    assign last_push = push & r_in_last;
    assign last_pop  = pop & r_out_last;
    // Full with no complete burst means the burst can never finish: deadlock escape.
    assign force_set = SF & full & (bursts == '0) & ~force_q;
    assign force_clr = force_q & ((last_pop & ~last_push & (bursts == CNT_W'(1)))
                                | (pop & ~push & (count == CNT_W'(1))));

    // Count of last beats currently held in the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bursts <= '0;
        end else if (last_push & ~last_pop) begin
            bursts <= bursts + CNT_W'(1);
        end else if (last_pop & ~last_push & (bursts != '0)) begin
            bursts <= bursts - CNT_W'(1);
        end
    end

    // Forced cut-through state and its one-cycle announcement pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            force_q     <= 1'b0;
            cut_through <= 1'b0;
        end else begin
            cut_through <= force_set;
            if (force_set) begin
                force_q <= 1'b1;
            end else if (force_clr) begin
                force_q <= 1'b0;
            end
        end
    end

endmodule
